fpadd_share_ctrl: RTL and testbench

- Round-robin controller that time-shares one LAT-stage single-precision FP adder pipeline among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues one pair per cycle into the shared adder.
- Tracks in-flight ownership with a tag shift register and routes each sum into that requester's one-entry response buffer.
- Sits between the FP add datapath (normalize/round path) and the client units that need additions.

---
 rtl/fpadd_share_ctrl.sv | 139 +++++++++++++
 tb/tb_fpadd_share_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_share_ctrl.sv
// Round-robin front end that time-shares one fixed-latency FP adder among NREQ clients.
// A tag shift register follows each issued pair so its sum lands in the owner's response buffer.
module fpadd_share_ctrl #(
    parameter int NREQ = 4,
    parameter int LAT  = 3,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*32-1:0]   rsp_data,
    output logic                 add_in_valid,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_res,
    output logic                 busy
);

    logic [31:0]     req_a_arr  [NREQ];
    logic [31:0]     req_b_arr  [NREQ];
    logic [31:0]     rsp_data_q [NREQ];
    logic [31:0]     rsp_data_d [NREQ];

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] outst_q, outst_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [LAT-1:0]  tag_vld_q, tag_vld_d;
    logic [IDW-1:0]  tag_idx_q [LAT];
    logic [IDW-1:0]  tag_idx_d [LAT];
    logic            add_in_valid_q, add_in_valid_d;
    logic [31:0]     add_a_q, add_a_d;
    logic [31:0]     add_b_q, add_b_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [IDW-1:0]  win;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign req_a_arr[gi]         = req_a[32*gi +: 32];
            assign req_b_arr[gi]         = req_b[32*gi +: 32];
            assign rsp_data[32*gi +: 32] = rsp_data_q[gi];
        end
    endgenerate

    // A requester with a sum still pending (in flight or unread) is not eligible.
    assign eligible = req_valid & ~outst_q;

    always_comb begin
        logic [IDW-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_any = 1'b0;
        win       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_any && eligible[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                grant_any  = 1'b1;
            end
        end
    end

    assign req_ready = grant & {NREQ{rst_n}};

    always_comb begin
        ptr_d          = ptr_q;
        add_in_valid_d = grant_any;
        add_a_d        = add_a_q;
        add_b_d        = add_b_q;
        tag_vld_d      = '0;
        tag_idx_d      = tag_idx_q;
        rsp_data_d     = rsp_data_q;

        if (grant_any) begin
            add_a_d = req_a_arr[win];
            add_b_d = req_b_arr[win];
            ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end

        tag_vld_d[0] = grant_any;
        tag_idx_d[0] = win;
        for (int k = LAT - 1; k >= 1; k--) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_idx_d[k] = tag_idx_q[k-1];
        end

        outst_d     = (outst_q & ~(rsp_valid_q & rsp_ready)) | grant;
        rsp_valid_d = rsp_valid_q & ~rsp_ready;

        // The owner is still outstanding, so its buffer is guaranteed empty here.
        if (tag_vld_q[LAT-1]) begin
            rsp_valid_d[tag_idx_q[LAT-1]] = 1'b1;
            rsp_data_d[tag_idx_q[LAT-1]]  = add_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= '0;
            outst_q        <= '0;
            rsp_valid_q    <= '0;
            tag_vld_q      <= '0;
            add_in_valid_q <= 1'b0;
            add_a_q        <= '0;
            add_b_q        <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_idx_q[k] <= '0;
            end
            for (int k = 0; k < NREQ; k++) begin
                rsp_data_q[k] <= '0;
            end
        end else begin
            ptr_q          <= ptr_d;
            outst_q        <= outst_d;
            rsp_valid_q    <= rsp_valid_d;
            tag_vld_q      <= tag_vld_d;
            add_in_valid_q <= add_in_valid_d;
            add_a_q        <= add_a_d;
            add_b_q        <= add_b_d;
            tag_idx_q      <= tag_idx_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign add_in_valid = add_in_valid_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign busy         = (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// Directed bench for fpadd_share_ctrl; the shared adder is modelled as a LAT-1 register pipe
// fed by a small table of hand-computed single-precision sums.
module tb_fpadd_share_ctrl;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [NREQ*32-1:0] rsp_data;
    logic               add_in_valid;
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [31:0]        add_res;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int g0;

    fpadd_share_ctrl #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .add_in_valid (add_in_valid),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_res      (add_res),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fsum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1 + 2 = 3
            {32'h40000000, 32'h40000000}: return 32'h40800000; // 2 + 2 = 4
            {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1 + 1 = 2
            {32'h3FC00000, 32'hBF000000}: return 32'h3F800000; // 1.5 - 0.5 = 1
            {32'h40A00000, 32'h3F800000}: return 32'h40C00000; // 5 + 1 = 6
            default:                      return 32'hBADC0DE0;
        endcase
    endfunction

    // Adder model: not reset, so stale sums keep flowing after a controller reset.
    logic [31:0] apipe [LAT-1];
    always @(posedge clk) begin
        apipe[0] <= add_in_valid ? fsum(add_a, add_b) : 32'hDEADBEEF;
        for (int k = 1; k < LAT - 1; k++) apipe[k] <= apipe[k-1];
    end
    assign add_res = apipe[LAT-2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 4'h0;
        req_a     = '0;
        req_b     = '0;

        // Reset state, with requests pending to show req_ready is held low
        @(negedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data0", rsp_data[31:0], 32'h0);
        chk("rst_add_valid", 32'(add_in_valid), 32'h0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        req_valid = 4'h0;
        @(negedge clk); rst_n = 1'b1;

        // Single op on requester 0: 1.0 + 2.0
        @(negedge clk);
        req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000; req_valid = 4'b0001; #1;
        chk("t1_grant0", 32'(req_ready), 32'h1);
        @(negedge clk); #1;
        chk("t1_add_valid", 32'(add_in_valid), 32'h1);
        chk("t1_add_a", add_a, 32'h3F800000);
        chk("t1_add_b", add_b, 32'h40000000);
        chk("t1_no_regrant", 32'(req_ready), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        @(negedge clk); #1;
        chk("t1_add_valid_drop", 32'(add_in_valid), 32'h0);
        chk("t1_rsp_early2", 32'(rsp_valid), 32'h0);
        @(negedge clk); #1;
        chk("t1_rsp_early3", 32'(rsp_valid), 32'h0);
        @(negedge clk); #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_data", rsp_data[31:0], 32'h40400000);
        chk("t1_ready_pending", 32'(req_ready), 32'h0);
        @(negedge clk); rsp_ready = 4'b0001; #1;
        chk("t1_rsp_hold", 32'(rsp_valid), 32'h1);
        chk("t1_ready_accept_cycle", 32'(req_ready), 32'h0);
        @(negedge clk); #1;
        chk("t1_rsp_cleared", 32'(rsp_valid), 32'h0);
        chk("t1_data_kept", rsp_data[31:0], 32'h40400000);
        chk("t1_regrant", 32'(req_ready), 32'h1);
        req_valid = 4'h0;
        @(negedge clk); #1;
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // All four requesters at once from ptr=0, responses drained immediately
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; rsp_ready = 4'hF;
        req_a = {32'h40A00000, 32'h3FC00000, 32'h3F800000, 32'h40000000};
        req_b = {32'h3F800000, 32'hBF000000, 32'h3F800000, 32'h40000000};
        @(negedge clk); req_valid = 4'hF; #1;
        chk("t2_grant0", 32'(req_ready), 32'b0001);
        @(negedge clk); #1;
        chk("t2_grant1", 32'(req_ready), 32'b0010);
        chk("t2_issue0", add_a, 32'h40000000);
        @(negedge clk); #1;
        chk("t2_grant2", 32'(req_ready), 32'b0100);
        chk("t2_issue1", add_a, 32'h3F800000);
        @(negedge clk); #1;
        chk("t2_grant3", 32'(req_ready), 32'b1000);
        chk("t2_issue2", add_a, 32'h3FC00000);
        @(negedge clk); req_valid = 4'h0; #1;
        chk("t2_issue3", add_a, 32'h40A00000);
        chk("t2_rsp0", 32'(rsp_valid), 32'b0001);
        chk("t2_data0", rsp_data[31:0], 32'h40800000);
        @(negedge clk); #1;
        chk("t2_rsp1", 32'(rsp_valid), 32'b0010);
        chk("t2_data1", rsp_data[63:32], 32'h40000000);
        @(negedge clk); #1;
        chk("t2_rsp2", 32'(rsp_valid), 32'b0100);
        chk("t2_data2", rsp_data[95:64], 32'h3F800000);
        @(negedge clk); #1;
        chk("t2_rsp3", 32'(rsp_valid), 32'b1000);
        chk("t2_data3", rsp_data[127:96], 32'h40C00000);
        @(negedge clk); #1;
        chk("t2_drained", 32'(rsp_valid), 32'h0);
        chk("t2_busy", 32'(busy), 32'h0);

        // Fairness: move ptr to 3 by granting 2, then 1 and 3 contend
        @(negedge clk); req_valid = 4'b0100; #1;
        chk("t3_grant2", 32'(req_ready), 32'b0100);
        @(negedge clk); req_valid = 4'h0;
        repeat (6) @(negedge clk);
        req_valid = 4'b1010; #1;
        chk("t3_first3", 32'(req_ready), 32'b1000);
        @(negedge clk); #1;
        chk("t3_then1_wrap", 32'(req_ready), 32'b0010);
        @(negedge clk); req_valid = 4'h0; #1;
        chk("t3_issue1", add_a, 32'h3F800000);
        repeat (6) @(negedge clk);

        // Backpressure on requester 1 (ptr=2 here)
        rsp_ready = 4'b1101; req_valid = 4'b0011; #1;
        chk("t4_grant0", 32'(req_ready), 32'b0001);
        @(negedge clk); #1;
        chk("t4_grant1", 32'(req_ready), 32'b0010);
        g0 = 0;
        for (int i = 2; i < 14; i++) begin
            @(negedge clk); #1;
            chk("t4_no_regrant1", 32'(req_ready[1]), 32'h0);
            if (req_ready[0]) g0++;
            if (i >= 5) begin
                chk("t4_rsp1_held", 32'(rsp_valid[1]), 32'h1);
                chk("t4_data1_stable", rsp_data[63:32], 32'h40000000);
            end
            if (i == 11) req_valid[0] = 1'b0;
        end
        chk("t4_req0_grants", 32'(g0), 32'd2);
        @(negedge clk); rsp_ready[1] = 1'b1; #1;
        chk("t4_accept_cycle", 32'(req_ready), 32'h0);
        chk("t4_rsp1_still", 32'(rsp_valid[1]), 32'h1);
        @(negedge clk); #1;
        chk("t4_regrant1", 32'(req_ready), 32'b0010);
        chk("t4_rsp_clear", 32'(rsp_valid), 32'h0);
        @(negedge clk); req_valid = 4'h0; rsp_ready = 4'hF;
        repeat (6) @(negedge clk);

        // Reset with three tags in flight (ptr=2: grants 2, 0, 1)
        req_valid = 4'b0111; #1;
        chk("t5_grant2", 32'(req_ready), 32'b0100);
        @(negedge clk); #1;
        chk("t5_grant0", 32'(req_ready), 32'b0001);
        @(negedge clk); #1;
        chk("t5_grant1", 32'(req_ready), 32'b0010);
        @(negedge clk); #1;
        chk("t5_busy_inflight", 32'(busy), 32'h1);
        req_valid = 4'h0; rst_n = 1'b0; #1;
        chk("t5_rst_req_ready", 32'(req_ready), 32'h0);
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_rst_rsp_data1", rsp_data[63:32], 32'h0);
        chk("t5_rst_add_valid", 32'(add_in_valid), 32'h0);
        chk("t5_rst_add_a", add_a, 32'h0);
        chk("t5_rst_add_b", add_b, 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t5_stale_rsp", 32'(rsp_valid), 32'h0);
            chk("t5_stale_busy", 32'(busy), 32'h0);
        end

        // Idle: ptr must survive 20 idle cycles (set to 3 first)
        @(negedge clk); req_valid = 4'b0100; #1;
        chk("t6_grant2", 32'(req_ready), 32'b0100);
        @(negedge clk); req_valid = 4'h0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("t6_idle_add_valid", 32'(add_in_valid), 32'h0);
            chk("t6_idle_busy", 32'(busy), 32'h0);
        end
        @(negedge clk); req_valid = 4'hF; #1;
        chk("t6_ptr_kept", 32'(req_ready), 32'b1000);
        req_valid = 4'h0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
